// File: rtl/ctrl_seq_pkg.sv
// Shared widths, opcodes, T-state encodings and control-word layout for the
// SAP-2 mini controller-sequencer.
package ctrl_seq_pkg;

    localparam int unsigned W   = 12;
    localparam int unsigned OPW = 4;
    localparam int unsigned TW  = 6;

    localparam logic [OPW-1:0] OP_LDA = 4'h0;
    localparam logic [OPW-1:0] OP_ADD = 4'h1;
    localparam logic [OPW-1:0] OP_SUB = 4'h2;
    localparam logic [OPW-1:0] OP_STA = 4'h3;
    localparam logic [OPW-1:0] OP_LDI = 4'h4;
    localparam logic [OPW-1:0] OP_JMP = 4'h5;
    localparam logic [OPW-1:0] OP_JZ  = 4'h6;
    localparam logic [OPW-1:0] OP_OUT = 4'hE;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    localparam logic [TW-1:0] T1 = 6'b000001;
    localparam logic [TW-1:0] T2 = 6'b000010;
    localparam logic [TW-1:0] T3 = 6'b000100;
    localparam logic [TW-1:0] T4 = 6'b001000;
    localparam logic [TW-1:0] T5 = 6'b010000;
    localparam logic [TW-1:0] T6 = 6'b100000;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lp;
        logic lm_n;
        logic ce_n;
        logic wr;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic lb_n;
        logic su;
        logic eu;
        logic lo_n;
    } ctrl_word_t;

    localparam ctrl_word_t IDLE_CW = '{
        cp: 1'b0, ep: 1'b0, lp: 1'b0, lm_n: 1'b1, ce_n: 1'b1, wr: 1'b0, li_n: 1'b1,
        ei_n: 1'b1, la_n: 1'b1, ea: 1'b0, lb_n: 1'b1, su: 1'b0, eu: 1'b0, lo_n: 1'b1
    };

    function automatic logic is_onehot(input logic [TW-1:0] v);
        return (v != '0) && ((v & (v - TW'(1))) == '0);
    endfunction

endpackage

// File: rtl/ctrl_seq_ring6.sv
// Six-stage one-hot T-state ring counter with clear, advance, return-to-T1
// and hold controls; any non-one-hot value falls back to T1.
module ctrl_seq_ring6
    import ctrl_seq_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          adv,
    input  logic          rst1,
    input  logic          hold,
    output logic [TW-1:0] t
);

    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;

    always_comb begin
        t_d = t_q;
        if (!is_onehot(t_q)) begin
            t_d = T1;
        end else if (hold) begin
            t_d = t_q;
        end else if (rst1) begin
            t_d = T1;
        end else if (adv) begin
            t_d = {t_q[TW-2:0], t_q[TW-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            t_q <= T1;
        end else begin
            t_q <= t_d;
        end
    end

    assign t = t_q;

endmodule

// File: rtl/ctrl_seq.sv
// SAP-2 mini controller-sequencer: steps the T-state ring and decodes the IR
// opcode plus zero flag into the datapath control word.
module ctrl_seq
    import ctrl_seq_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic [W-1:0]  ir,
    input  logic          z,
    output logic [TW-1:0] t,
    output logic          cp,
    output logic          ep,
    output logic          lp,
    output logic          lm_n,
    output logic          ce_n,
    output logic          wr,
    output logic          li_n,
    output logic          ei_n,
    output logic          la_n,
    output logic          ea,
    output logic          lb_n,
    output logic          su,
    output logic          eu,
    output logic          lo_n,
    output logic          hlt
);

    logic [OPW-1:0] op;
    logic           unused_addr;
    ctrl_word_t     cw;
    logic           adv;
    logic           rst1;
    logic           hold;
    logic           hlt_now;
    logic           halt_q;
    logic           halt_d;

    assign op          = ir[W-1 -: OPW];
    assign unused_addr = ^ir[W-OPW-1:0];

    ctrl_seq_ring6 u_ring (
        .clk  (clk),
        .clr  (clr),
        .adv  (adv),
        .rst1 (rst1),
        .hold (hold),
        .t    (t)
    );

    // Control word and ring steering from (t, opcode, z); clr overrides to idle.
    always_comb begin
        cw      = IDLE_CW;
        adv     = 1'b0;
        rst1    = 1'b0;
        hold    = 1'b0;
        hlt_now = 1'b0;
        if (halt_q) begin
            hold = 1'b1;
        end else begin
            case (t)
                T1: begin cw.ep = 1'b1; cw.lm_n = 1'b0; adv = 1'b1; end
                T2: begin cw.cp = 1'b1; adv = 1'b1; end
                T3: begin cw.ce_n = 1'b0; cw.li_n = 1'b0; adv = 1'b1; end
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            cw.ei_n = 1'b0; cw.lm_n = 1'b0; adv = 1'b1;
                        end
                        OP_LDI: begin cw.ei_n = 1'b0; cw.la_n = 1'b0; rst1 = 1'b1; end
                        OP_JMP: begin cw.ei_n = 1'b0; cw.lp = 1'b1; rst1 = 1'b1; end
                        OP_JZ: begin
                            cw.ei_n = ~z;
                            cw.lp   = z;
                            rst1    = 1'b1;
                        end
                        OP_OUT: begin cw.ea = 1'b1; cw.lo_n = 1'b0; rst1 = 1'b1; end
                        OP_HLT: begin hlt_now = 1'b1; hold = 1'b1; end
                        default: rst1 = 1'b1;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA: begin cw.ce_n = 1'b0; cw.la_n = 1'b0; rst1 = 1'b1; end
                        OP_ADD, OP_SUB: begin cw.ce_n = 1'b0; cw.lb_n = 1'b0; adv = 1'b1; end
                        OP_STA: begin cw.ea = 1'b1; cw.wr = 1'b1; rst1 = 1'b1; end
                        default: rst1 = 1'b1;
                    endcase
                end
                T6: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        cw.eu   = 1'b1;
                        cw.la_n = 1'b0;
                        cw.su   = (op == OP_SUB);
                    end
                    rst1 = 1'b1;
                end
                default: ;
            endcase
        end
        if (clr) begin
            cw      = IDLE_CW;
            hlt_now = 1'b0;
        end
    end

    assign halt_d = halt_q | hlt_now;

    // Sticky halt flag; only clr releases it.
    always_ff @(posedge clk) begin
        if (clr) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign cp   = cw.cp;
    assign ep   = cw.ep;
    assign lp   = cw.lp;
    assign lm_n = cw.lm_n;
    assign ce_n = cw.ce_n;
    assign wr   = cw.wr;
    assign li_n = cw.li_n;
    assign ei_n = cw.ei_n;
    assign la_n = cw.la_n;
    assign ea   = cw.ea;
    assign lb_n = cw.lb_n;
    assign su   = cw.su;
    assign eu   = cw.eu;
    assign lo_n = cw.lo_n;
    assign hlt  = ~clr & (halt_q | hlt_now);

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: directed scenarios then random instruction
// streams, checked against an instruction-length/microcode-table model.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] ir;
    logic         z;
    logic [5:0]   t;
    logic cp, ep, lp, lm_n, ce_n, wr, li_n, ei_n, la_n, ea, lb_n, su, eu, lo_n, hlt;

    always #5 clk = ~clk;

    ctrl_seq dut (
        .clk(clk), .clr(clr), .ir(ir), .z(z), .t(t),
        .cp(cp), .ep(ep), .lp(lp), .lm_n(lm_n), .ce_n(ce_n), .wr(wr),
        .li_n(li_n), .ei_n(ei_n), .la_n(la_n), .ea(ea), .lb_n(lb_n),
        .su(su), .eu(eu), .lo_n(lo_n), .hlt(hlt)
    );

    // Active-sense signal bits in vector order cp..lo_n; LOWS marks active-low pins.
    localparam bit [13:0] S_CP = 14'h2000, S_EP = 14'h1000, S_LP = 14'h0800, S_LM = 14'h0400;
    localparam bit [13:0] S_CE = 14'h0200, S_WR = 14'h0100, S_LI = 14'h0080, S_EI = 14'h0040;
    localparam bit [13:0] S_LA = 14'h0020, S_EA = 14'h0010, S_LB = 14'h0008, S_SU = 14'h0004;
    localparam bit [13:0] S_EU = 14'h0002, S_LO = 14'h0001;
    localparam bit [13:0] LOWS = S_LM | S_CE | S_LI | S_EI | S_LA | S_LB | S_LO;

    typedef struct {
        logic [20:0] vec;
        logic [20:0] mask;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [20:0] mon_got;
    int          n_vec = 0;
    int          n_err = 0;

    int          m_step = -1;
    bit          m_halt = 1'b0;
    logic [5:0]  m_illegal = 6'b0;
    logic [W-1:0] cur_ir;
    logic        rnd_c;
    int          halt_cnt;

    function automatic int ilen(input logic [3:0] op);
        case (op)
            4'h0, 4'h3: return 5;
            4'h1, 4'h2: return 6;
            default:    return 4;
        endcase
    endfunction

    function automatic bit [13:0] micro(input int s, input logic [3:0] op, input logic zz);
        case (s)
            1: return S_EP | S_LM;
            2: return S_CP;
            3: return S_CE | S_LI;
            4: case (op)
                4'h0, 4'h1, 4'h2, 4'h3: return S_EI | S_LM;
                4'h4: return S_EI | S_LA;
                4'h5: return S_EI | S_LP;
                4'h6: return zz ? (S_EI | S_LP) : 14'h0;
                4'hE: return S_EA | S_LO;
                default: return 14'h0;
            endcase
            5: case (op)
                4'h0: return S_CE | S_LA;
                4'h1, 4'h2: return S_CE | S_LB;
                4'h3: return S_EA | S_WR;
                default: return 14'h0;
            endcase
            6: case (op)
                4'h1: return S_EU | S_LA;
                4'h2: return S_EU | S_LA | S_SU;
                default: return 14'h0;
            endcase
            default: return 14'h0;
        endcase
    endfunction

    function automatic logic [5:0] tvec(input int s);
        return 6'(1) << (s - 1);
    endfunction

    // Drive one cycle, push its expected outputs, then step the model.
    task automatic apply(input logic c, input logic [W-1:0] i, input logic zz, input string tag);
        exp_t       e;
        logic [3:0] op;
        bit [13:0]  act;
        clr = c;
        ir  = i;
        z   = zz;
        op  = i[W-1 -: 4];
        e.mask = '1;
        e.name = $sformatf("%s step%0d op%h z%0d clr%0d", tag, m_step, op, zz, c);
        if (m_step < 0) e.mask[20:15] = 6'b0;
        if (c || m_step <= 0 || m_halt) act = 14'h0;
        else act = micro(m_step, op, zz);
        e.vec[20:15] = (m_step == 0) ? m_illegal : ((m_step > 0) ? tvec(m_step) : 6'b0);
        e.vec[14:1]  = act ^ LOWS;
        e.vec[0]     = !c && (m_step > 0) && (m_halt || (m_step == 4 && op == 4'hF));
        sb_q.push_back(e);
        if (c) begin
            m_step = 1;
            m_halt = 1'b0;
        end else if (m_step == 0) begin
            m_step = 1;
        end else if (m_halt) begin
            m_step = m_step;
        end else if (m_step == 4 && op == 4'hF) begin
            m_halt = 1'b1;
        end else if (m_step >= ilen(op)) begin
            m_step = 1;
        end else begin
            m_step = m_step + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [W-1:0] i, input logic zz, input int n, input string tag);
        for (int k = 0; k < n; k++) apply(1'b0, i, zz, tag);
    endtask

    // Monitor: output is presented every cycle; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_got = {t, cp, ep, lp, lm_n, ce_n, wr, li_n, ei_n, la_n, ea, lb_n, su, eu, lo_n, hlt};
            n_vec++;
            if (((mon_got ^ mon_e.vec) & mon_e.mask) !== 21'b0) begin
                n_err++;
                $display("FAIL %s: got t=%b cw=%b hlt=%b, want t=%b cw=%b hlt=%b",
                         mon_e.name, mon_got[20:15], mon_got[14:1], mon_got[0],
                         mon_e.vec[20:15], mon_e.vec[14:1], mon_e.vec[0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1;
        ir  = '0;
        z   = 1'b0;
        @(posedge clk);
        #1;
        apply(1'b1, 12'h000, 1'b0, "reset");
        apply(1'b1, 12'h000, 1'b0, "reset");
        run_instr(12'h02A, 1'b0, 5, "LDA");
        run_instr(12'h210, 1'b1, 6, "SUB");
        run_instr(12'h605, 1'b1, 4, "JZ taken");
        run_instr(12'h605, 1'b0, 4, "JZ not taken");
        run_instr(12'hF00, 1'b0, 14, "HLT");
        apply(1'b1, 12'hF00, 1'b0, "HLT clr");
        run_instr(12'h433, 1'b0, 4, "LDI");
        run_instr(12'h1AB, 1'b0, 4, "ADD");
        apply(1'b1, 12'h1AB, 1'b0, "ADD clr T5");
        run_instr(12'h1AB, 1'b0, 6, "ADD refetch");
        run_instr(12'h3C4, 1'b1, 5, "STA");
        run_instr(12'hE00, 1'b0, 4, "OUT");
        run_instr(12'h5F0, 1'b0, 4, "JMP");
        run_instr(12'h9FF, 1'b1, 2, "NOP");

        force dut.u_ring.t_q = 6'b000011;
        #1;
        release dut.u_ring.t_q;
        m_step    = 0;
        m_illegal = 6'b000011;
        apply(1'b0, 12'h9FF, 1'b0, "illegal t");
        run_instr(12'h9FF, 1'b0, 4, "after recover");

        halt_cnt = 0;
        cur_ir   = 12'h000;
        for (int k = 0; k < 3000; k++) begin
            if (m_step <= 1) cur_ir = W'($urandom);
            if (m_halt) halt_cnt++;
            else halt_cnt = 0;
            rnd_c = ($urandom_range(0, 59) == 0) || (halt_cnt > 6);
            apply(rnd_c, cur_ir, 1'($urandom), "rand");
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
